// File: rtl/top_datapath_pkg.sv
// Shared constants for the single-cycle datapath: widths, sizes, ALU opcodes
// and the instruction ROM program.
package top_datapath_pkg;

    localparam int DATA_W    = 32;
    localparam int NUM_REGS  = 32;
    localparam int ROM_DEPTH = 64;
    localparam int REG_AW    = $clog2(NUM_REGS);
    localparam int ROM_AW    = $clog2(ROM_DEPTH);

    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_SUB = 4'b0110,
        ALU_SLT = 4'b0111,
        ALU_NOR = 4'b1100
    } alu_op_e;

    // Preloaded program; every word not listed here reads as zero.
    localparam logic [DATA_W-1:0] PROG_ADDI_1 = 32'h2001_0005; // addi $1,$0,5
    localparam logic [DATA_W-1:0] PROG_ADDI_2 = 32'h2002_000A; // addi $2,$0,10
    localparam logic [DATA_W-1:0] PROG_ADD_3  = 32'h0022_1820; // add  $3,$1,$2

    function automatic logic [DATA_W-1:0] rom_word(input logic [ROM_AW-1:0] idx);
        logic [DATA_W-1:0] w;
        w = '0;
        case (idx)
            6'd0:    w = PROG_ADDI_1;
            6'd1:    w = PROG_ADDI_2;
            6'd2:    w = PROG_ADD_3;
            default: w = '0;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/top_datapath_alu.sv
// Combinational ALU: AND, OR, ADD, SUB; SLT and NOR only when ALU_EXT_OPS_EN
// is defined. Unsupported codes yield zero.
import top_datapath_pkg::*;

module alu (
    input  logic [3:0]        alu_op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] result
);

    // Select the operation result for the current opcode.
    always_comb begin
        // NOTE: default assigned first so no path through the case leaves result unassigned (no latch).
        result = '0;
        case (alu_op)
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
`ifdef ALU_EXT_OPS_EN
            ALU_SLT: result = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_NOR: result = ~(a | b);
`endif
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/top_datapath.sv
// Single-cycle datapath slice: PC, 64-word instruction ROM, 32x32 register
// file, destination/operand muxes and the ALU. Optional ALU ops are enabled
// with macro ALU_EXT_OPS_EN.
import top_datapath_pkg::*;

module top_datapath (
    input  logic              clk,
    input  logic              rst,
    input  logic              rst_rf,
    input  logic              en,
    input  logic              en_rf,
    input  logic              selec_mux,
    input  logic              selec_mux2,
    input  logic [3:0]        alu_op,
    output logic [DATA_W-1:0] fim
);

    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] instr;
    logic [DATA_W-1:0] rf [NUM_REGS];
    logic [REG_AW-1:0] rs_addr;
    logic [REG_AW-1:0] rt_addr;
    logic [REG_AW-1:0] rd_addr;
    logic [REG_AW-1:0] wr_addr;
    logic [DATA_W-1:0] rd_data1;
    logic [DATA_W-1:0] rd_data2;
    logic [DATA_W-1:0] imm_ext;
    logic [DATA_W-1:0] alu_b;
    logic              unused_opcode;

    // Program counter: advance by one word when enabled, otherwise hold.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: non-blocking assignment for registered state so all flops update together at the edge.
        if (rst)
            pc <= '0;
        else if (en)
            pc <= pc + DATA_W'(4);
    end

    // Instruction fetch: word-addressed ROM, index wraps every 64 words.
    always_comb begin
        instr = rom_word(pc[ROM_AW+1:2]);
    end

    assign rs_addr       = instr[25:21];
    assign rt_addr       = instr[20:16];
    assign rd_addr       = instr[15:11];
    assign imm_ext       = {{(DATA_W-16){instr[15]}}, instr[15:0]};
    assign unused_opcode = ^instr[31:26];

    // Destination register select: rt for immediate forms, rd for register forms.
    always_comb begin
        wr_addr = selec_mux ? rd_addr : rt_addr;
    end

    // Register file write port; $0 is never written.
    always_ff @(posedge clk or posedge rst_rf) begin
        // NOTE: the whole array is cleared on reset because the register file must read zero afterwards; this forces flops rather than RAM.
        if (rst_rf) begin
            for (int i = 0; i < NUM_REGS; i++)
                rf[i] <= '0;
        end else if (en_rf && (wr_addr != '0)) begin
            rf[wr_addr] <= fim;
        end
    end

    // Read ports: combinational, no bypass of a write in the same cycle.
    always_comb begin
        rd_data1 = (rs_addr == '0) ? '0 : rf[rs_addr];
        rd_data2 = (rt_addr == '0) ? '0 : rf[rt_addr];
    end

    // ALU B operand: register data or sign-extended immediate.
    always_comb begin
        alu_b = selec_mux2 ? imm_ext : rd_data2;
    end

    alu u_alu (
        .alu_op (alu_op),
        .a      (rd_data1),
        .b      (alu_b),
        .result (fim)
    );

endmodule

// File: tb/tb_top_datapath.sv
// Self-checking bench for top_datapath: table-driven vectors with a
// scoreboard queue plus hand-written reset/priority/wrap sequences.
module tb_top_datapath;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rst_rf = 1'b1;
    logic        en = 1'b0;
    logic        en_rf = 1'b0;
    logic        selec_mux = 1'b0;
    logic        selec_mux2 = 1'b0;
    logic [3:0]  alu_op = 4'b0000;
    logic [31:0] fim;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic        en;
        logic        en_rf;
        logic        mux;
        logic        mux2;
        logic [3:0]  op;
        logic [31:0] exp_pc;
        logic [31:0] exp_fim;
        int          chk_reg;   // -1: no register check after the edge
        logic [31:0] reg_val;
    } vec_t;

    vec_t        prog_tbl[$];
    vec_t        ops_tbl[$];
    logic [31:0] exp_q[$];

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1100;
    localparam logic [3:0] OP_BAD = 4'b1111;
    localparam logic [3:0] OP_UNU = 4'b0011;

    top_datapath dut (
        .clk        (clk),
        .rst        (rst),
        .rst_rf     (rst_rf),
        .en         (en),
        .en_rf      (en_rf),
        .selec_mux  (selec_mux),
        .selec_mux2 (selec_mux2),
        .alu_op     (alu_op),
        .fim        (fim)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one vector on the falling edge, compare, then take the rising edge.
    task automatic apply(input string tag, input vec_t v);
        logic [31:0] exp;
        @(negedge clk);
        en         = v.en;
        en_rf      = v.en_rf;
        selec_mux  = v.mux;
        selec_mux2 = v.mux2;
        alu_op     = v.op;
        exp_q.push_back(v.exp_fim);
        #1;
        check({tag, " pc"}, dut.pc, v.exp_pc);
        exp = exp_q.pop_front();
        check({tag, " fim"}, fim, exp);
        @(posedge clk);
        #1;
        if (v.chk_reg >= 0)
            check($sformatf("%s reg%0d", tag, v.chk_reg), dut.rf[v.chk_reg], v.reg_val);
    endtask

    initial begin
        // Program run: addi, addi, add.
        prog_tbl.push_back('{1'b1, 1'b1, 1'b0, 1'b1, OP_ADD, 32'd0, 32'd5,  1, 32'd5});
        prog_tbl.push_back('{1'b1, 1'b1, 1'b0, 1'b1, OP_ADD, 32'd4, 32'd10, 2, 32'd10});
        prog_tbl.push_back('{1'b1, 1'b1, 1'b1, 1'b0, OP_ADD, 32'd8, 32'd15, 3, 32'd15});
        // Hold for three cycles at PC=12 (word3 is zero).
        for (int i = 0; i < 3; i++)
            prog_tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, OP_ADD, 32'd12, 32'd0, -1, 32'd0});

        // At PC=0 after restart: A=$0=0, B=$1=5.
        ops_tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, OP_AND, 32'd0, 32'd0,         -1, 32'd0});
        ops_tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, OP_OR,  32'd0, 32'd5,         -1, 32'd0});
        ops_tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, OP_SUB, 32'd0, 32'hFFFF_FFFB, -1, 32'd0});
        ops_tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, OP_UNU, 32'd0, 32'd0,         -1, 32'd0});
        // Write to $0 (rd field of word0 is 0) must be ignored.
        ops_tbl.push_back('{1'b0, 1'b1, 1'b1, 1'b1, OP_ADD, 32'd0, 32'd5,          0, 32'd0});
        ops_tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b1, OP_ADD, 32'd0, 32'd5,         -1, 32'd0});
        // Advance to PC=8 without writing.
        ops_tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b0, OP_OR,  32'd0, 32'd5,         -1, 32'd0});
        ops_tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b0, OP_OR,  32'd4, 32'd10,        -1, 32'd0});
        // At PC=8: A=$1=5, B=$2=10 or imm 0x1820.
        ops_tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, OP_AND, 32'd8, 32'd0,         -1, 32'd0});
        ops_tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, OP_OR,  32'd8, 32'd15,        -1, 32'd0});
        ops_tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, OP_ADD, 32'd8, 32'd15,        -1, 32'd0});
        ops_tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, OP_SUB, 32'd8, 32'hFFFF_FFFB, -1, 32'd0});
`ifdef ALU_EXT_OPS_EN
        ops_tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, OP_SLT, 32'd8, 32'd1,         -1, 32'd0});
        ops_tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, OP_NOR, 32'd8, 32'hFFFF_FFF0, -1, 32'd0});
`else
        ops_tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, OP_SLT, 32'd8, 32'd0,         -1, 32'd0});
        ops_tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, OP_NOR, 32'd8, 32'd0,         -1, 32'd0});
`endif
        ops_tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, OP_BAD, 32'd8, 32'd0,         -1, 32'd0});
        ops_tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b1, OP_ADD, 32'd8, 32'h0000_1825, -1, 32'd0});

        // Reset both PC and register file for two cycles, release with en=0.
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst    = 1'b0;
        rst_rf = 1'b0;
        #1;
        check("reset pc", dut.pc, 32'd0);
        check("reset fim and", fim, 32'd0);
        for (int i = 0; i < 32; i++)
            check($sformatf("reset reg%0d", i), dut.rf[i], 32'd0);

        foreach (prog_tbl[i])
            apply($sformatf("prog%0d", i), prog_tbl[i]);

        // Asynchronous rst pulse between edges: PC clears at once, registers kept.
        @(negedge clk);
        alu_op     = OP_ADD;
        selec_mux2 = 1'b1;
        #2 rst = 1'b1;
        #1;
        check("rst pulse pc", dut.pc, 32'd0);
        check("rst pulse fim", fim, 32'd5);
        rst = 1'b0;
        #1;
        check("retain reg1", dut.rf[1], 32'd5);
        check("retain reg2", dut.rf[2], 32'd10);
        check("retain reg3", dut.rf[3], 32'd15);

        foreach (ops_tbl[i])
            apply($sformatf("ops%0d", i), ops_tbl[i]);

        // rst takes priority over en across a clock edge.
        @(negedge clk);
        en  = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst over en pc", dut.pc, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        en  = 1'b0;

        // rst_rf takes priority over a write to $1 on the same edge.
        @(negedge clk);
        en_rf      = 1'b1;
        selec_mux  = 1'b0;
        selec_mux2 = 1'b1;
        alu_op     = OP_ADD;
        rst_rf     = 1'b1;
        @(posedge clk);
        #1;
        check("rst_rf over en_rf reg1", dut.rf[1], 32'd0);
        check("rst_rf clears reg2", dut.rf[2], 32'd0);
        check("rst_rf clears reg3", dut.rf[3], 32'd0);
        @(negedge clk);
        rst_rf = 1'b0;
        en_rf  = 1'b0;

        // ROM wraps after 64 words: PC=256 fetches word0 again.
        @(negedge clk);
        en = 1'b1;
        repeat (64) @(posedge clk);
        @(negedge clk);
        en = 1'b0;
        #1;
        check("wrap pc", dut.pc, 32'd256);
        check("wrap fim", fim, 32'd5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/top_datapath.md
TOP_DATAPATH -- requirements
Module: top_datapath

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: clk input 1, rising-edge clock for all state; rst input 1, async active-high reset of the PC.
REQ-002 The block SHALL have input rst_rf (1 bit): async active-high reset of the register file.
REQ-003 The block SHALL have input en (1 bit): PC update enable.
REQ-004 The block SHALL have input en_rf (1 bit): register-file write enable.
REQ-005 The block SHALL have input selec_mux (1 bit): destination select; 0 selects rt (instr[20:16]), 1 selects rd (instr[15:11]).
REQ-006 The block SHALL have input selec_mux2 (1 bit): ALU B-operand select; 0 selects register read data 2, 1 selects the sign-extended imm.
REQ-007 The block SHALL have input alu_op (4 bits): ALU operation code.
REQ-008 The block SHALL have output fim (32 bits): combinational ALU result.

Function
REQ-009 The PC SHALL be a 32-bit register; on a rising clk edge with en=1 it SHALL load PC+4 (mod 2^32); with en=0 it SHALL hold its value.
REQ-010 The instruction ROM SHALL hold 64 words, indexed by PC[7:2], and SHALL wrap at the 64-word boundary.
REQ-011 The ROM SHALL be preloaded with: word0=0x20010005 (addi $1,$0,5); word1=0x2002000A (addi $2,$0,10); word2=0x00221820 (add $3,$1,$2); all other words SHALL be 0x00000000.
REQ-012 The register file SHALL have 32x32 bits, two combinational read ports (rs=instr[25:21], rt=instr[20:16]) and one synchronous write port.
REQ-013 On a rising clk edge with en_rf=1, the register file SHALL write fim to the register selected by selec_mux.
REQ-014 Register $0 SHALL always read 0; writes to $0 SHALL be ignored.
REQ-015 A write SHALL become visible on the read ports only after the writing edge; no same-cycle bypass.
REQ-016 The immediate SHALL be instr[15:0], sign-extended to 32 bits.
REQ-017 The ALU SHALL compute A=read data 1 and B=mux2 output.
REQ-018 ALU operations: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB; all other codes SHALL yield 0.
REQ-019 ADD and SUB SHALL be 32-bit two's complement, wrapping, with no overflow flag.
REQ-020 fim SHALL depend combinationally on the PC, register contents and control inputs, with no output latency.

Reset
REQ-021 rst=1 SHALL asynchronously clear the PC to 0; fim then reflects ROM word0.
REQ-022 rst_rf=1 SHALL asynchronously clear all 32 registers to 0.
REQ-023 rst_rf SHALL take priority over a simultaneous en_rf write, and rst SHALL take priority over en.
REQ-024 Asserting rst mid-program SHALL restart execution at word0 and SHALL leave register contents unchanged unless rst_rf is also asserted.

Configuration
REQ-025 With macro ALU_EXT_OPS_EN defined, the ALU SHALL also implement 0111 SLT (signed; result 1 or 0) and 1100 NOR.
REQ-026 Without ALU_EXT_OPS_EN, codes 0111 and 1100 SHALL yield 0.

Structure
REQ-027 A shared package SHALL hold the ALU opcode constants, the data width (32), the register count (32), the ROM depth (64) and the ROM initial program.
REQ-028 The ALU SHALL be a separate sub-module named alu; the PC, ROM, register file and muxes SHALL reside in top_datapath.

Verification
REQ-029 Bench SHALL check: rst=rst_rf=1 for 2 cycles, then release with en=0 -> PC=0, fim=0 at alu_op=0000, and all register reads return 0.
REQ-030 Bench SHALL check: en=en_rf=1, alu_op=0010, selec_mux=0, selec_mux2=1 at PC=0 -> fim=5, and $1=5 after the edge.
REQ-031 Bench SHALL check: same controls at PC=4 -> fim=10, and $2=10 after the edge.
REQ-032 Bench SHALL check: selec_mux=1, selec_mux2=0, alu_op=0010 at PC=8 -> fim=15, and $3=15 after the edge.
REQ-033 Bench SHALL check: en=0 for 3 cycles -> PC and fim unchanged; rst pulsed between edges -> PC=0 immediately, registers retained.
REQ-034 Bench SHALL check: with ALU_EXT_OPS_EN defined and alu_op=0111 at PC=8 after the program has run -> fim=1 ($1=5 < $2=10); alu_op=0110 -> fim=0xFFFFFFFB.
